ps2_tx: RTL and testbench



---
 rtl/ps2_tx_if.sv | 28 ++
 rtl/ps2_tx.sv | 272 +++++++++++++++++++++++++++
 tb/tb_ps2_tx.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_tx_if.sv
// ps2_tx_if: command-byte handshake between a host controller and ps2_tx.
// master = the block that issues bytes; slave = the transmitter itself.
interface ps2_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_err;
  logic       busy;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_done,
    input  tx_err,
    input  busy
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_done,
    output tx_err,
    output busy
  );
endinterface

// File: rtl/ps2_tx.sv
// ps2_tx: PS/2 host-to-device transmitter.
// Sends one command byte (start, 8 data bits LSB first, odd parity, stop),
// checks the device ACK and reports tx_done or tx_err. The shared lines are
// driven only through registered pull-low enables.
// Optional build macro PS2TX_CLK_FILTER_EN adds a FILT_LEN-sample glitch
// filter on the synchronized ps2clk before falling-edge detection.
module ps2_tx #(
  parameter int INHIBIT_CYC = 3000,
  parameter int TIMEOUT_CYC = 50000,
  parameter int FILT_LEN    = 4
) (
  input  logic    clk,
  input  logic    reset,
  ps2_tx_if.slave bus,
  input  logic    ps2clk,
  input  logic    ps2dat,
  output logic    ps2clk_oe,
  output logic    ps2dat_oe
);

  localparam int TMR_MAX = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] INH_PRE  = TMR_W'(INHIBIT_CYC - 2);
  localparam logic [TMR_W-1:0] INH_LAST = TMR_W'(INHIBIT_CYC - 1);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYC - 1);

  // The start bit is raised one cycle before the inhibit ends, so at least
  // two inhibit cycles are needed; the filter needs at least one sample.
  generate
    if (INHIBIT_CYC < 2) begin : g_bad_inhibit
      $error("ps2_tx: INHIBIT_CYC must be >= 2");
    end
    if (FILT_LEN < 1) begin : g_bad_filt
      $error("ps2_tx: FILT_LEN must be >= 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    DATA,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [TMR_W-1:0] tmr;
  logic [TMR_W-1:0] tmr_nx;
  logic [3:0]       bitcnt;
  logic [3:0]       bitcnt_nx;
  logic [9:0]       shift;
  logic [9:0]       shift_nx;
  logic             clk_oe_r;
  logic             clk_oe_nx;
  logic             dat_oe_r;
  logic             dat_oe_nx;
  logic             done_r;
  logic             done_nx;
  logic             err_r;
  logic             err_nx;

  logic clk_meta;
  logic sync_clk;
  logic dat_meta;
  logic sync_dat;
  logic edge_lvl;
  logic sync_clk_prev;
  logic fe;
  logic accept;
  logic timed_out;

  // Two-flop synchronizers; lines idle high, so reset to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_meta <= 1'b1;
      sync_clk <= 1'b1;
      dat_meta <= 1'b1;
      sync_dat <= 1'b1;
    end else begin
      clk_meta <= ps2clk;
      sync_clk <= clk_meta;
      dat_meta <= ps2dat;
      sync_dat <= dat_meta;
    end
  end

`ifdef PS2TX_CLK_FILTER_EN
  localparam int FC_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [FC_W-1:0] filt_cnt;
  logic            filt_lvl;

  // Filtered clock level follows sync_clk only after FILT_LEN differing samples in a row.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_lvl <= 1'b1;
      filt_cnt <= '0;
    end else if (sync_clk == filt_lvl) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FC_W'(FILT_LEN - 1)) begin
      filt_lvl <= sync_clk;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  assign edge_lvl = filt_lvl;
`else
  assign edge_lvl = sync_clk;
`endif

  // Previous clock level for falling-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_clk_prev <= 1'b1;
    end else begin
      sync_clk_prev <= edge_lvl;
    end
  end

  assign fe        = sync_clk_prev & ~edge_lvl;
  assign accept    = bus.tx_valid & bus.tx_ready;
  assign timed_out = (tmr == TMO_LAST);

  // Next-state, line-enable and pulse logic for the transfer sequence.
  always_comb begin
    state_nx  = state;
    tmr_nx    = tmr + 1'b1;
    bitcnt_nx = bitcnt;
    shift_nx  = shift;
    clk_oe_nx = clk_oe_r;
    dat_oe_nx = dat_oe_r;
    done_nx   = 1'b0;
    err_nx    = 1'b0;

    unique case (state)
      IDLE: begin
        clk_oe_nx = 1'b0;
        dat_oe_nx = 1'b0;
        tmr_nx    = '0;
        if (accept) begin
          shift_nx  = {1'b1, ~^bus.tx_data, bus.tx_data};
          bitcnt_nx = '0;
          clk_oe_nx = 1'b1;
          state_nx  = INHIBIT;
        end
      end

      INHIBIT: begin
        // Device edges are ignored here: the host owns the clock line.
        clk_oe_nx = 1'b1;
        if (tmr == INH_PRE) begin
          dat_oe_nx = 1'b1;
        end
        if (tmr == INH_LAST) begin
          clk_oe_nx = 1'b0;
          dat_oe_nx = 1'b1;
          tmr_nx    = '0;
          state_nx  = START;
        end
      end

      START: begin
        if (fe) begin
          dat_oe_nx = ~shift[0];
          shift_nx  = {1'b1, shift[9:1]};
          bitcnt_nx = 4'd1;
          tmr_nx    = '0;
          state_nx  = DATA;
        end else if (timed_out) begin
          clk_oe_nx = 1'b0;
          dat_oe_nx = 1'b0;
          err_nx    = 1'b1;
          state_nx  = IDLE;
        end
      end

      DATA: begin
        if (fe) begin
          // The tenth edge presents the stop bit (a 1), which releases the data line.
          dat_oe_nx = ~shift[0];
          shift_nx  = {1'b1, shift[9:1]};
          bitcnt_nx = bitcnt + 1'b1;
          tmr_nx    = '0;
          if (bitcnt == 4'd9) begin
            state_nx = ACK;
          end
        end else if (timed_out) begin
          clk_oe_nx = 1'b0;
          dat_oe_nx = 1'b0;
          err_nx    = 1'b1;
          state_nx  = IDLE;
        end
      end

      ACK: begin
        if (fe) begin
          tmr_nx = '0;
          if (!sync_dat) begin
            state_nx = WAIT_IDLE;
          end else begin
            err_nx   = 1'b1;
            state_nx = IDLE;
          end
        end else if (timed_out) begin
          clk_oe_nx = 1'b0;
          dat_oe_nx = 1'b0;
          err_nx    = 1'b1;
          state_nx  = IDLE;
        end
      end

      WAIT_IDLE: begin
        if (sync_clk && sync_dat) begin
          done_nx  = 1'b1;
          state_nx = IDLE;
        end else if (timed_out) begin
          clk_oe_nx = 1'b0;
          dat_oe_nx = 1'b0;
          err_nx    = 1'b1;
          state_nx  = IDLE;
        end
      end

      default: begin
        clk_oe_nx = 1'b0;
        dat_oe_nx = 1'b0;
        state_nx  = IDLE;
      end
    endcase
  end

  // Control state: FSM, watchdog, bit counter, line enables and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tmr      <= '0;
      bitcnt   <= '0;
      clk_oe_r <= 1'b0;
      dat_oe_r <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state    <= state_nx;
      tmr      <= tmr_nx;
      bitcnt   <= bitcnt_nx;
      clk_oe_r <= clk_oe_nx;
      dat_oe_r <= dat_oe_nx;
      done_r   <= done_nx;
      err_r    <= err_nx;
    end
  end

  // Frame shift register; pure data, reloaded on every accepted byte.
  always_ff @(posedge clk) begin
    shift <= shift_nx;
  end

  assign ps2clk_oe    = clk_oe_r;
  assign ps2dat_oe    = dat_oe_r;
  assign bus.tx_done  = done_r;
  assign bus.tx_err   = err_r;
  assign bus.busy     = (state != IDLE);
  // Ready is held off during the completion pulse so a held tx_valid cannot
  // start a second transfer in the same cycle the first one reports.
  assign bus.tx_ready = (state == IDLE) & ~done_r & ~err_r;

endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx: directed bench for ps2_tx with a behavioural PS/2 device that
// clocks 40-cycle bit periods, samples data at each rising clock and ACKs.
`timescale 1ns/1ps
module tb_ps2_tx;

  localparam int INH = 20;
  localparam int TMO = 200;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ps2_tx_if bus ();

  logic ps2clk_oe;
  logic ps2dat_oe;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  logic ps2clk_line;
  logic ps2dat_line;

  // Open-drain wired-AND of host and device pull-downs.
  assign ps2clk_line = ~(ps2clk_oe | dev_clk_low);
  assign ps2dat_line = ~(ps2dat_oe | dev_dat_low);

  ps2_tx #(
    .INHIBIT_CYC (INH),
    .TIMEOUT_CYC (TMO),
    .FILT_LEN    (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .ps2clk    (ps2clk_line),
    .ps2dat    (ps2dat_line),
    .ps2clk_oe (ps2clk_oe),
    .ps2dat_oe (ps2dat_oe)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int acc_cnt  = 0;

  // Count status pulses and accepted handshakes.
  always @(posedge clk) begin
    if (bus.tx_done) done_cnt <= done_cnt + 1;
    if (bus.tx_err) err_cnt <= err_cnt + 1;
    if (bus.tx_valid && bus.tx_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called on a negedge with tx_ready high; returns on the next negedge.
  task automatic send(input logic [7:0] b, input bit hold);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    if (!hold) bus.tx_valid = 1'b0;
  endtask

  // Device model. got = {stop, parity, data[7:0], start} as seen on the line.
  task automatic dev_xfer(input int stop_after, input bit ack_low, input bit clk_dead,
                          input int glitch_bit, output int inh_len, output logic [10:0] got);
    int guard;
    got = '1;
    inh_len = 0;
    guard = 0;
    while (!ps2clk_oe && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    while (ps2clk_oe && inh_len < 1000) begin
      inh_len++;
      @(negedge clk);
    end
    got[0] = ps2dat_line;
    if (clk_dead) return;
    repeat (10) @(negedge clk);
    for (int i = 1; i <= 10; i++) begin
      dev_clk_low = 1'b1;
      if (i == stop_after) begin
        repeat (10) @(negedge clk);
        return;
      end
      repeat (20) @(negedge clk);
      dev_clk_low = 1'b0;
      got[i] = ps2dat_line;
      if (i == glitch_bit) begin
        repeat (5) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (2) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (13) @(negedge clk);
      end else if (i == 10) begin
        repeat (10) @(negedge clk);
        dev_dat_low = ack_low;
        repeat (10) @(negedge clk);
      end else begin
        repeat (20) @(negedge clk);
      end
    end
    dev_clk_low = 1'b1;
    repeat (20) @(negedge clk);
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
  endtask

  // Wait (bounded) for the transmitter to return to IDLE with ready high.
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!(bus.tx_ready && !bus.busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, {31'd0, bus.tx_ready}, 32'd1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          inh;
    logic [10:0] got;
    int          d0, e0, a0, n;
    bit          seen;

    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check_eq("rst_ready", {31'd0, bus.tx_ready}, 32'd1);
    check_eq("rst_busy",  {31'd0, bus.busy},     32'd0);
    check_eq("rst_pulses", {30'd0, bus.tx_done, bus.tx_err}, 32'd0);
    check_eq("rst_oe", {30'd0, ps2clk_oe, ps2dat_oe}, 32'd0);

    // 0xED LED set: start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1
    d0 = done_cnt; e0 = err_cnt;
    send(8'hED, 1'b0);
    dev_xfer(0, 1'b1, 1'b0, 0, inh, got);
    check_eq("ed_inhibit_len", inh, 32'd20);
    check_eq("ed_frame", {21'd0, got}, {21'd0, 11'b11111011010});
    check_eq("ed_parity", {31'd0, got[9]}, 32'd1);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 50) begin
      if (bus.tx_done) seen = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    check_eq("ed_done_seen", {31'd0, seen}, 32'd1);
    @(negedge clk);
    check_eq("ed_ready_after", {30'd0, bus.tx_ready, bus.tx_done}, 32'd2);
    check_eq("ed_done_cnt", done_cnt - d0, 32'd1);
    check_eq("ed_err_cnt", err_cnt - e0, 32'd0);

    // 0xF4 enable with tx_valid held through the transfer
    d0 = done_cnt; a0 = acc_cnt;
    send(8'hF4, 1'b1);
    dev_xfer(0, 1'b1, 1'b0, 0, inh, got);
    check_eq("f4_inhibit_len", inh, 32'd20);
    check_eq("f4_frame", {21'd0, got}, {21'd0, 11'b10111101000});
    seen = 1'b0;
    n = 0;
    while (!seen && n < 50) begin
      if (bus.tx_done) seen = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    bus.tx_valid = 1'b0;
    check_eq("f4_done_seen", {31'd0, seen}, 32'd1);
    repeat (5) @(negedge clk);
    check_eq("f4_accepts", acc_cnt - a0, 32'd1);
    check_eq("f4_done_cnt", done_cnt - d0, 32'd1);
    check_eq("f4_idle", {30'd0, bus.busy, ps2clk_oe}, 32'd0);

    // Device never clocks: error 200 cycles after START entry
    d0 = done_cnt; e0 = err_cnt;
    send(8'h55, 1'b0);
    dev_xfer(0, 1'b1, 1'b1, 0, inh, got);
    check_eq("tmo_start_bit", {31'd0, got[0]}, 32'd0);
    n = 0;
    while (!bus.tx_err && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq("tmo_latency", n, 32'd200);
    check_eq("tmo_oe", {30'd0, ps2clk_oe, ps2dat_oe}, 32'd0);
    check_eq("tmo_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    check_eq("tmo_err_cnt", err_cnt - e0, 32'd1);
    check_eq("tmo_done_cnt", done_cnt - d0, 32'd0);
    wait_ready("tmo_ready");

    // Missing ACK
    d0 = done_cnt; e0 = err_cnt;
    send(8'h00, 1'b0);
    dev_xfer(0, 1'b0, 1'b0, 0, inh, got);
    check_eq("nak_frame", {21'd0, got}, {21'd0, 11'b11000000000});
    wait_ready("nak_ready");
    check_eq("nak_err_cnt", err_cnt - e0, 32'd1);
    check_eq("nak_done_cnt", done_cnt - d0, 32'd0);

    // Reset during data bit 4, then a clean 0xFF reset command
    d0 = done_cnt; e0 = err_cnt;
    send(8'h3C, 1'b0);
    dev_xfer(4, 1'b1, 1'b0, 0, inh, got);
    check_eq("mid_busy", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("mid_rst_oe", {30'd0, ps2clk_oe, ps2dat_oe}, 32'd0);
    check_eq("mid_rst_ready", {31'd0, bus.tx_ready}, 32'd1);
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("mid_no_pulse", (done_cnt - d0) + (err_cnt - e0), 32'd0);
    send(8'hFF, 1'b0);
    dev_xfer(0, 1'b1, 1'b0, 0, inh, got);
    check_eq("ff_frame", {21'd0, got}, {21'd0, 11'b11111111110});
    check_eq("ff_parity", {31'd0, got[9]}, 32'd1);
    wait_ready("ff_ready");
    check_eq("ff_done_cnt", done_cnt - d0, 32'd1);
    check_eq("ff_err_cnt", err_cnt - e0, 32'd0);

`ifdef PS2TX_CLK_FILTER_EN
    // Two-cycle clock glitch in DATA must not advance the bit count
    d0 = done_cnt; e0 = err_cnt;
    send(8'hA5, 1'b0);
    dev_xfer(0, 1'b1, 1'b0, 3, inh, got);
    check_eq("glitch_frame", {21'd0, got}, {21'd0, 11'b11101001010});
    wait_ready("glitch_ready");
    check_eq("glitch_done_cnt", done_cnt - d0, 32'd1);
    check_eq("glitch_err_cnt", err_cnt - e0, 32'd0);
`endif

    // Totals: one outcome pulse per completed or aborted byte, none for the reset one
    check_eq("total_accepts", acc_cnt, done_cnt + err_cnt + 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
